// File: rtl/mem_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared constants for the memory arbiter: FSM state encoding,
//            access-size codes and the size-to-byte-count helper.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   // mm_size codes; code 3 is not named and falls through to a word access
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Instruction fetches are always full words
   localparam logic [2:0] IF_NBYTES = 3'd4;

   // Number of bytes moved for a given size code
   function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SIZE_BYTE: n = 3'd1;
         SIZE_HALF: n = 3'd2;
         SIZE_WORD: n = 3'd4;
         default:   n = 3'd4;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates one instruction-fetch port and one data port onto a
//            byte-wide RAM. Data port wins in IDLE; transactions are
//            non-preemptive and move 1, 2 or 4 bytes, one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   // instruction fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_done,
   output logic [31:0] if_data,
   // data port
   input  logic        mm_req,
   input  logic        mm_we,
   input  logic [1:0]  mm_size,
   input  logic [31:0] mm_addr,
   input  logic [31:0] mm_wdata,
   output logic        mm_done,
   output logic [31:0] mm_rdata,
   // RAM side
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr
);

   state_e      state_q,   state_d;
   logic [2:0]  cnt_q,     cnt_d;      // byte index of the current address phase
   logic [2:0]  nbytes_q,  nbytes_d;
   logic [31:0] addr_q,    addr_d;
   logic [31:0] wdata_q,   wdata_d;
   logic [31:0] data_q,    data_d;     // read assembly register
   logic        is_if_q,   is_if_d;    // current transaction belongs to the fetch port
   logic        if_done_q, if_done_d;
   logic        mm_done_q, mm_done_d;

   // Read data arriving now belongs to the address issued one cycle earlier
   logic [1:0]  cap_idx;
   assign cap_idx = cnt_q[1:0] - 2'd1;

   // State and datapath registers; async active-low reset clears everything
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 3'd0;
         nbytes_q  <= 3'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         data_q    <= 32'd0;
         is_if_q   <= 1'b0;
         if_done_q <= 1'b0;
         mm_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         nbytes_q  <= nbytes_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         data_q    <= data_d;
         is_if_q   <= is_if_d;
         if_done_q <= if_done_d;
         mm_done_q <= mm_done_d;
      end
   end

   // Next-state logic: grant, byte sequencing, capture, flush and completion
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      nbytes_d  = nbytes_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      data_d    = data_q;
      is_if_d   = is_if_q;
      if_done_d = 1'b0;
      mm_done_d = 1'b0;

      if (!rdy_in) begin
         // Paused: everything freezes, including a pending done pulse
         if_done_d = if_done_q;
         mm_done_d = mm_done_q;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // A port whose done is high this cycle is not re-granted
               if (mm_req && !mm_done_q) begin
                  addr_d   = mm_addr;
                  nbytes_d = size_to_nbytes(mm_size);
                  wdata_d  = mm_wdata;
                  data_d   = 32'd0;
                  is_if_d  = 1'b0;
                  cnt_d    = 3'd0;
                  state_d  = mm_we ? ST_WRITE : ST_READ;
               end else if (if_req && !if_done_q) begin
                  addr_d   = if_addr;
                  nbytes_d = IF_NBYTES;
                  wdata_d  = 32'd0;
                  data_d   = 32'd0;
                  is_if_d  = 1'b1;
                  cnt_d    = 3'd0;
                  state_d  = ST_READ;
               end
            end

            ST_READ: begin
               if (is_if_q && if_flush) begin
                  // Jump taken: drop the fetch silently
                  state_d = ST_IDLE;
                  cnt_d   = 3'd0;
               end else begin
                  if (cnt_q != 3'd0) begin
                     data_d[{cap_idx, 3'b000} +: 8] = mem_din;
                  end
                  if (cnt_q == nbytes_q) begin
                     state_d = ST_IDLE;
                     cnt_d   = 3'd0;
                     if (is_if_q) begin
                        if_done_d = 1'b1;
                     end else begin
                        mm_done_d = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end

            ST_WRITE: begin
               if (cnt_q == (nbytes_q - 3'd1)) begin
                  state_d   = ST_IDLE;
                  cnt_d     = 3'd0;
                  mm_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   // RAM-side drive: address/data from registered state, writes blocked while paused
   always_comb begin
      mem_a    = 32'd0;
      mem_dout = 8'd0;
      mem_wr   = 1'b0;
      if (state_q != ST_IDLE) begin
         mem_a = addr_q + {29'd0, cnt_q};
      end
      if (state_q == ST_WRITE) begin
         mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
         mem_wr   = rdy_in;
      end
   end

   assign if_done  = if_done_q;
   assign mm_done  = mm_done_q;
   assign if_data  = data_q;
   assign mm_rdata = data_q;

endmodule
`default_nettype wire
